// File: rtl/frv_mem_pkg.sv
// Shared types and widths for the frv memory arbiter slice.
package frv_mem_pkg;

  localparam int MEM_AW = 32;
  localparam int MEM_DW = 32;
  localparam int MEM_SW = 4;

  typedef enum logic {
    MID_I = 1'b0,
    MID_D = 1'b1
  } mem_id_t;

endpackage

// File: rtl/frv_mem_arb_idfifo.sv
// In-order FIFO of master IDs for granted-but-unanswered requests.
// No bypass: a pushed ID becomes visible at the head one cycle later.
module frv_mem_arb_idfifo
  import frv_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    g_clk,
  input  logic    g_resetn,
  input  logic    i_push,
  input  mem_id_t i_pushId,
  input  logic    i_pop,
  output mem_id_t o_head,
  output logic    o_full,
  output logic    o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  mem_id_t         r_mem [DEPTH];
  logic [PW-1:0]   r_wrPtr;
  logic [PW-1:0]   r_rdPtr;
  logic [CW-1:0]   r_count;
  logic            w_doPush;
  logic            w_doPop;

  // Pointers wrap at DEPTH, which need not fill the pointer width.
  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == CW'(DEPTH));
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign o_head   = r_mem[r_rdPtr];

  always_ff @(posedge g_clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_pushId;
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= nextPtr(r_wrPtr);
      if (w_doPop)  r_rdPtr <= nextPtr(r_rdPtr);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/frv_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the instruction and
// data masters; responses are routed back in grant order via an ID FIFO.
module frv_mem_arbiter
  import frv_mem_pkg::*;
#(
  parameter int OUTSTANDING = 2
) (
  input  logic              g_clk,
  input  logic              g_resetn,

  input  logic              i_req,
  input  logic              i_wen,
  input  logic [MEM_SW-1:0] i_strb,
  input  logic [MEM_DW-1:0] i_wdata,
  input  logic [MEM_AW-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_recv,
  output logic              i_error,
  output logic [MEM_DW-1:0] i_rdata,
  input  logic              i_ack,

  input  logic              d_req,
  input  logic              d_wen,
  input  logic [MEM_SW-1:0] d_strb,
  input  logic [MEM_DW-1:0] d_wdata,
  input  logic [MEM_AW-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_recv,
  output logic              d_error,
  output logic [MEM_DW-1:0] d_rdata,
  input  logic              d_ack,

  output logic              s_req,
  output logic              s_wen,
  output logic [MEM_SW-1:0] s_strb,
  output logic [MEM_DW-1:0] s_wdata,
  output logic [MEM_AW-1:0] s_addr,
  input  logic              s_gnt,
  input  logic              s_recv,
  input  logic              s_error,
  input  logic [MEM_DW-1:0] s_rdata,
  output logic              s_ack
);

  logic    r_lock;
  mem_id_t r_lockId;
  mem_id_t r_lastId;

  mem_id_t w_sel;
  mem_id_t w_head;
  logic    w_full;
  logic    w_empty;
  logic    w_selReq;
  logic    w_xfer;
  logic    w_pop;

  // A stalled request stays with its master; otherwise the loser of the
  // previous transfer wins a conflict.
  always_comb begin
    w_sel = r_lastId;
    if (r_lock)              w_sel = r_lockId;
    else if (i_req && !d_req) w_sel = MID_I;
    else if (d_req && !i_req) w_sel = MID_D;
    else                      w_sel = (r_lastId == MID_I) ? MID_D : MID_I;
  end

  assign w_selReq = (w_sel == MID_D) ? d_req : i_req;
  assign s_req    = w_selReq && !w_full;
  assign s_wen    = (w_sel == MID_D) ? d_wen   : i_wen;
  assign s_strb   = (w_sel == MID_D) ? d_strb  : i_strb;
  assign s_wdata  = (w_sel == MID_D) ? d_wdata : i_wdata;
  assign s_addr   = (w_sel == MID_D) ? d_addr  : i_addr;

  assign w_xfer = s_req && s_gnt;
  assign i_gnt  = w_xfer && (w_sel == MID_I);
  assign d_gnt  = w_xfer && (w_sel == MID_D);

  assign i_recv  = s_recv && !w_empty && (w_head == MID_I);
  assign d_recv  = s_recv && !w_empty && (w_head == MID_D);
  assign i_rdata = i_recv ? s_rdata : '0;
  assign d_rdata = d_recv ? s_rdata : '0;
  assign i_error = i_recv && s_error;
  assign d_error = d_recv && s_error;

  // With nothing outstanding any response is spurious and simply absorbed.
  assign s_ack = w_empty ? 1'b1 : ((w_head == MID_D) ? d_ack : i_ack);
  assign w_pop = s_recv && s_ack && !w_empty;

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_lock   <= 1'b0;
      r_lockId <= MID_I;
      r_lastId <= MID_I;
    end else if (s_req && !s_gnt) begin
      r_lock   <= 1'b1;
      r_lockId <= w_sel;
    end else if (w_xfer) begin
      r_lock   <= 1'b0;
      r_lastId <= w_sel;
    end
  end

  frv_mem_arb_idfifo #(
    .DEPTH (OUTSTANDING)
  ) u_idfifo (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .i_push   (w_xfer),
    .i_pushId (w_sel),
    .i_pop    (w_pop),
    .o_head   (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

endmodule
